cbus_arbiter: RTL

//  Shares the single memory-side cbus port between NUM_REQ cache masters
//  (slot 0 = DCache, slot 1 = ICache).

---
 rtl/cbus_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: shares the memory-side cbus port between cache masters.
// CBUS_ARB_RR_EN selects round-robin, otherwise fixed priority (0 first).
package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  len;
    logic [63:0] data;
    logic [7:0]  strobe;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [NUM_REQ],
  output cbus_resp_t iresps [NUM_REQ],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [SW-1:0] LAST_IDX = SW'(NUM_REQ - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [SW-1:0] sel_q;
  logic [SW-1:0] sel_d;

  logic [NUM_REQ-1:0] vld;
  logic               any_vld;
  logic [SW-1:0]      win;
  logic               done;
  logic               abort;

  // gather request valids into a vector
  always_comb begin
    vld = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      vld[i] = ireqs[i].valid;
    end
  end

  assign any_vld = |vld;
  assign done    = oresp.ready && oresp.last;
  assign abort   = !ireqs[sel_q].valid;

`ifdef CBUS_ARB_RR_EN

  logic [SW-1:0] rr_q;
  logic [SW-1:0] rr_d;
  logic          found;
  logic [SW:0]   idx;

  // first valid index at or above rr_q, wrapping
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_q} + (SW+1)'(k);
      if (idx >= (SW+1)'(NUM_REQ)) begin
        idx = idx - (SW+1)'(NUM_REQ);
      end
      if (!found && vld[idx[SW-1:0]]) begin
        win   = idx[SW-1:0];
        found = 1'b1;
      end
    end
  end

  // pointer moves past the master whose burst just completed
  always_comb begin
    rr_d = rr_q;
    if (state_q == BUSY && done) begin
      rr_d = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;
    end
  end

  // round-robin pointer register
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

`else

  // lowest valid index wins, so the DCache always beats the ICache
  always_comb begin
    win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (vld[i]) begin
        win = SW'(i);
      end
    end
  end

`endif

  // grant on any request; hold until completion or abort
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (any_vld) begin
          state_d = BUSY;
          sel_d   = win;
        end
      end
      BUSY: begin
        if (done || abort) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // route the granted request out and the memory response back
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      iresps[i] = '0;
    end
    if (state_q == BUSY) begin
      oreq = ireqs[sel_q];
      for (int i = 0; i < NUM_REQ; i++) begin
        if (sel_q == SW'(i)) begin
          iresps[i] = oresp;
        end
      end
    end
  end

  // FSM state and grant index registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

endmodule
